// File: rtl/register_wneg_clkneg_universal.sv
// Falling-edge universal register: load, shift, rotate and multi-cycle rotate-by-N.
// Define REGISTER_UNIVERSAL_PARITY_EN to add a registered Parity output.
module register_wneg_clkneg_universal #(
    parameter int              WIDTH       = 8,
    parameter int              AW          = $clog2(WIDTH),
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             Clkbar,
    input  logic             Reset,
    input  logic             Enbar,
    input  logic [2:0]       Mode,
    input  logic [WIDTH-1:0] in,
    input  logic             SerialInLsb,
    input  logic             SerialInMsb,
    input  logic [AW-1:0]    Amount,
    output logic [WIDTH-1:0] out,
`ifdef REGISTER_UNIVERSAL_PARITY_EN
    output logic             Parity,
`endif
    output logic             SerialOutMsb,
    output logic             SerialOutLsb,
    output logic             Busy,
    output logic             Done
);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t          state;
    logic [AW-1:0]   counter;
    logic [WIDTH-1:0] out_next;

    assign SerialOutMsb = out[WIDTH-1];
    assign SerialOutLsb = out[0];

    // Next register contents for the non-reset case; Mode 111 never moves out in IDLE.
    always_comb begin
        out_next = out;
        if (!Enbar) begin
            if (state == SHIFT) begin
                out_next = {out[WIDTH-2:0], out[WIDTH-1]};
            end else begin
                case (Mode)
                    3'b001:  out_next = in;
                    3'b010:  out_next = {out[WIDTH-2:0], SerialInLsb};
                    3'b011:  out_next = {SerialInMsb, out[WIDTH-1:1]};
                    3'b100:  out_next = {out[WIDTH-2:0], out[WIDTH-1]};
                    3'b101:  out_next = {out[0], out[WIDTH-1:1]};
                    3'b110:  out_next = {out[WIDTH-1], out[WIDTH-1:1]};
                    default: out_next = out;
                endcase
            end
        end
    end

    always_ff @(negedge Clkbar) begin
        if (Reset) begin
            out     <= RESET_VALUE;
            state   <= IDLE;
            counter <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
`ifdef REGISTER_UNIVERSAL_PARITY_EN
            Parity  <= ^RESET_VALUE;
`endif
        end else begin
            Done <= 1'b0;
            out  <= out_next;
`ifdef REGISTER_UNIVERSAL_PARITY_EN
            Parity <= ^out_next;
`endif
            case (state)
                IDLE: begin
                    if (!Enbar && Mode == 3'b111) begin
                        if (Amount == '0) begin
                            Done <= 1'b1;
                        end else begin
                            counter <= Amount;
                            Busy    <= 1'b1;
                            state   <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    // Enbar high pauses the rotate with counter and Busy held.
                    if (!Enbar) begin
                        counter <= counter - AW'(1);
                        if (counter == AW'(1)) begin
                            state <= IDLE;
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_register_wneg_clkneg_universal.sv
// Directed-vector bench for register_wneg_clkneg_universal at WIDTH=8.
module tb_register_wneg_clkneg_universal;

    logic       Clkbar = 1'b1;
    logic       Reset, Enbar, SerialInLsb, SerialInMsb;
    logic [2:0] Mode;
    logic [7:0] in, out;
    logic [2:0] Amount;
    logic       SerialOutMsb, SerialOutLsb, Busy, Done;
`ifdef REGISTER_UNIVERSAL_PARITY_EN
    logic       Parity;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    register_wneg_clkneg_universal #(.WIDTH(8)) dut (
        .Clkbar(Clkbar), .Reset(Reset), .Enbar(Enbar), .Mode(Mode), .in(in),
        .SerialInLsb(SerialInLsb), .SerialInMsb(SerialInMsb), .Amount(Amount),
        .out(out),
`ifdef REGISTER_UNIVERSAL_PARITY_EN
        .Parity(Parity),
`endif
        .SerialOutMsb(SerialOutMsb), .SerialOutLsb(SerialOutLsb),
        .Busy(Busy), .Done(Done)
    );

    always #5 Clkbar = ~Clkbar;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one falling edge and settle before sampling.
    task automatic tick();
        @(negedge Clkbar);
        #1;
    endtask

    task automatic op(input logic [2:0] m, input logic [7:0] d);
        Enbar = 1'b0; Mode = m; in = d;
        tick();
    endtask

    task automatic st(input string tag, input logic [7:0] o, input logic b, input logic d);
        chk({tag, ".out"}, 32'(out), 32'(o));
        chk({tag, ".busy"}, 32'(Busy), 32'(b));
        chk({tag, ".done"}, 32'(Done), 32'(d));
    endtask

    initial begin
        Reset = 1'b1; Enbar = 1'b1; Mode = 3'b000; in = 8'h00;
        SerialInLsb = 1'b0; SerialInMsb = 1'b0; Amount = 3'd0;
        #2;
        tick();
        st("reset", 8'h00, 1'b0, 1'b0);

        Reset = 1'b0; Enbar = 1'b1; Mode = 3'b001; in = 8'hFF;
        tick();
        chk("enbar_hold", 32'(out), 32'h00);

        op(3'b001, 8'hAA); chk("load_aa", 32'(out), 32'hAA);
        op(3'b110, 8'h00); chk("asr", 32'(out), 32'hD5);
        SerialInMsb = 1'b0;
        op(3'b011, 8'h00); chk("lsr", 32'(out), 32'h6A);
        chk("sout_msb", 32'(SerialOutMsb), 32'd0);
        chk("sout_lsb", 32'(SerialOutLsb), 32'd0);

        op(3'b001, 8'h81); SerialInLsb = 1'b1;
        op(3'b010, 8'h00); chk("shl", 32'(out), 32'h03);
        chk("sout_lsb1", 32'(SerialOutLsb), 32'd1);
        op(3'b001, 8'h81); op(3'b100, 8'h00); chk("rol", 32'(out), 32'h03);
        op(3'b001, 8'h81); op(3'b101, 8'h00); chk("ror", 32'(out), 32'hC0);
        chk("sout_msb1", 32'(SerialOutMsb), 32'd1);
        op(3'b000, 8'h55); chk("hold_mode", 32'(out), 32'hC0);

        // Rotate-by-3, uninterrupted; Mode/in changes during SHIFT are ignored.
        op(3'b001, 8'h01); Amount = 3'd3;
        op(3'b111, 8'h00); st("rot_cmd", 8'h01, 1'b1, 1'b0);
        Amount = 3'd6;
        op(3'b001, 8'hEE); st("rot_s1", 8'h02, 1'b1, 1'b0);
        op(3'b001, 8'hEE); st("rot_s2", 8'h04, 1'b1, 1'b0);
        op(3'b001, 8'hEE); st("rot_s3", 8'h08, 1'b0, 1'b1);
        Enbar = 1'b1; tick(); st("rot_after", 8'h08, 1'b0, 1'b0);

        // Rotate-by-3 with a 2-edge pause.
        op(3'b001, 8'h01); Amount = 3'd3;
        op(3'b111, 8'h00); st("pz_cmd", 8'h01, 1'b1, 1'b0);
        op(3'b000, 8'h00); st("pz_s1", 8'h02, 1'b1, 1'b0);
        Enbar = 1'b1; tick(); st("pz_p1", 8'h02, 1'b1, 1'b0);
        tick(); st("pz_p2", 8'h02, 1'b1, 1'b0);
        op(3'b000, 8'h00); st("pz_s2", 8'h04, 1'b1, 1'b0);
        op(3'b000, 8'h00); st("pz_s3", 8'h08, 1'b0, 1'b1);

        // Reset during SHIFT aborts with no Done.
        op(3'b001, 8'h01); Amount = 3'd3;
        op(3'b111, 8'h00); op(3'b000, 8'h00); st("ab_s1", 8'h02, 1'b1, 1'b0);
        Reset = 1'b1; tick(); st("ab_rst", 8'h00, 1'b0, 1'b0);
        Reset = 1'b0; op(3'b000, 8'h00); st("ab_post", 8'h00, 1'b0, 1'b0);

        // Amount=0 completes immediately.
        op(3'b001, 8'h5A); Amount = 3'd0;
        op(3'b111, 8'h00); st("amt0", 8'h5A, 1'b0, 1'b1);
        Enbar = 1'b1; tick(); st("amt0_after", 8'h5A, 1'b0, 1'b0);

        // Next command is accepted on the edge right after Done.
        Amount = 3'd1;
        op(3'b111, 8'h00); st("b2b_cmd", 8'h5A, 1'b1, 1'b0);
        op(3'b000, 8'h00); st("b2b_s1", 8'hB4, 1'b0, 1'b1);

`ifdef REGISTER_UNIVERSAL_PARITY_EN
        op(3'b001, 8'h07); chk("parity_07", 32'(Parity), 32'd1);
        op(3'b100, 8'h00); chk("parity_rol", 32'(Parity), 32'd1);
        op(3'b001, 8'h03); chk("parity_03", 32'(Parity), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/register_wneg_clkneg_universal.md
Name: register_wneg_clkneg_universal

Overview:
- Parametrised successor to the 8-bit falling-edge, active-low-enable register.
- Adds configurable width, a synchronous reset and a mode-selected operation set: parallel load, single-step shift and rotate, and a multi-cycle rotate-by-N driven by an FSM.
- Used as a general datapath register and shifter in the negative-clock register family.

Parameters:
- WIDTH, 8, register width; must be a power of two and at least 2.
- AW, $clog2(WIDTH), width of Amount; derived, not to be overridden.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into out on reset.

Ports:
- Clkbar  input  1  clock; all state updates on the falling edge.
- Reset  input  1  synchronous, active-high reset, sampled on the falling edge of Clkbar.
- Enbar  input  1  active-low operation enable.
- Mode  input  3  operation select.
- in  input  WIDTH  parallel load data.
- SerialInLsb  input  1  bit entering at out[0] on shift left.
- SerialInMsb  input  1  bit entering at out[WIDTH-1] on logical shift right.
- Amount  input  AW  rotate count for Mode 111, range 0..WIDTH-1.
- out  output  WIDTH  register contents.
- SerialOutMsb  output  1  combinational copy of out[WIDTH-1].
- SerialOutLsb  output  1  combinational copy of out[0].
- Busy  output  1  high while a multi-cycle rotate is in progress.
- Done  output  1  one-cycle pulse when a Mode 111 command completes.

Behaviour:
- Reset=1 at a falling edge:
  - out<=RESET_VALUE, Busy<=0, Done<=0, FSM<=IDLE, counter<=0.
  - Reset overrides Enbar and Mode, and aborts any rotate in progress.
- Done defaults to 0 on every edge unless it is set as described below.
- FSM states: IDLE and SHIFT.
- IDLE with Enbar=1: out holds.
- IDLE with Enbar=0, one-edge latency, Mode decoded as:
  - 000: hold.
  - 001: out<=in.
  - 010: out<={out[WIDTH-2:0],SerialInLsb}.
  - 011: out<={SerialInMsb,out[WIDTH-1:1]}.
  - 100: rotate left by 1.
  - 101: rotate right by 1.
  - 110: arithmetic shift right; MSB is replicated.
  - 111, Amount=0: Done<=1 on this edge, out unchanged, FSM stays IDLE, Busy stays 0.
  - 111, Amount=k>0: counter<=k, Busy<=1, FSM<=SHIFT, out unchanged on this edge.
- SHIFT:
  - Enbar=0: each edge rotates out left by 1 and decrements counter.
  - Enbar=1: pause; out and counter hold, Busy stays 1.
  - On the rotating edge where counter==1: FSM<=IDLE, Busy<=0, Done<=1.
  - Net effect: Busy is high for k active cycles; the result equals the original value rotated left by k; Done coincides with Busy falling.
  - Mode, in, Amount and the serial inputs are ignored while in SHIFT.
- A new command is accepted on the edge after Done, if Enbar=0.
- Reset asserted during SHIFT returns the block to IDLE with out=RESET_VALUE; no Done is generated.
- Serial outputs update combinationally from out.

Optional Feature:
- Macro: REGISTER_UNIVERSAL_PARITY_EN.
- Defined:
  - Adds output port Parity (1 bit), registered, equal to ^out after each edge.
  - Reset value is ^RESET_VALUE.
  - Parity updates on every edge where out changes, including SHIFT steps.
- Undefined:
  - Port Parity is absent and no parity logic is built.
  - All other behaviour is identical.

Test Plan:
- Reset=1 for 1 edge, WIDTH=8 -> out=00000000, Busy=0, Done=0; then Enbar=1, Mode=001, in=8'hFF -> out stays 00000000.
- Enbar=0, Mode=001, in=8'hAA -> out=10101010 one edge later; Mode=110 -> 11010101; Mode=011 with SerialInMsb=0 -> 01101010.
- out=8'h81, Mode=010 with SerialInLsb=1 -> 00000011; Mode=100 on 8'h81 -> 00000011; Mode=101 on 8'h81 -> 11000000.
- out=8'h01, Mode=111, Amount=3 -> Busy=1 for 3 edges, out steps 02,04,08, Done=1 exactly on the edge out=08.
- Same command with Enbar=1 for 2 edges mid-rotate -> out and Busy hold; completion delayed by 2 edges; final out=08.
- Reset=1 during SHIFT -> out=00, Busy=0, Done never asserts. Mode=111 with Amount=0 -> Done=1 for one cycle, Busy stays 0. With REGISTER_UNIVERSAL_PARITY_EN, load 8'h07 -> Parity=1.
